// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// Generic pipeline stage register with a valid/ready handshake. It carries an
// opaque payload bus and a control bus between two adjacent pipeline stages
// (used at ID/EX, EX/MEM and MEM/WB). Features: stall back-pressure, optional
// two-entry skid buffer, flush, bubble insertion on the control bus and a
// saturating stall-cycle counter.
//
// Parameters
//   PAYLOAD_W : data payload width (operands, store data)
//   CTRL_W    : side-effecting control bits (dmem we, wb_select, alu op, ...)
//   SKID      : 1 = two-entry skid buffer, in_ready from registers + flush
//               0 = single register, in_ready passes out_ready through
//
// Ports
//   sys_clk     : clock, all state updates on the rising edge
//   sys_rst     : synchronous, active-low reset
//   in_valid    : upstream presents an instruction
//   in_ready    : this stage accepts this cycle
//   in_payload  : upstream data
//   in_ctrl     : upstream control
//   out_valid   : main entry holds a live instruction
//   out_ready   : downstream accepts; low means stall
//   out_payload : main-entry data (stale value visible while invalid)
//   out_ctrl    : main-entry control, forced to zero (bubble) when invalid
//   flush       : kill all contents at the next edge
//   occ         : number of held entries, 0..2 (not gated by flush)
//   stall_cnt   : saturating count of cycles with out_valid & ~out_ready
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int PAYLOAD_W = 100,
  parameter int CTRL_W    = 16,
  parameter int SKID      = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  input  logic                 flush,
  output logic [1:0]           occ,
  output logic [15:0]          stall_cnt
);

  // Occupancy state, decoded from {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  logic                 main_v,   main_v_n;
  logic [PAYLOAD_W-1:0] main_p,   main_p_n;
  logic [CTRL_W-1:0]    main_c,   main_c_n;
  logic                 skid_v,   skid_v_n;
  logic [PAYLOAD_W-1:0] skid_p,   skid_p_n;
  logic [CTRL_W-1:0]    skid_c,   skid_c_n;
  logic [15:0]          stall_cnt_n;

  state_t state;
  logic   in_fire;
  logic   out_fire;

  assign state = state_t'({skid_v, main_v});

  // With the skid buffer, in_ready comes from registers only, which breaks the
  // combinational out_ready -> in_ready path through the pipeline.
  assign in_ready = (SKID != 0) ? (~flush & ~skid_v)
                                : (~flush & (~main_v | out_ready));

  assign out_valid   = main_v & ~flush;
  assign out_payload = main_p;
  // Bubble: control bits are zeroed so an invalid slot never writes memory,
  // writes back a register or redirects the pc.
  assign out_ctrl    = out_valid ? main_c : '0;
  assign occ         = {1'b0, main_v} + {1'b0, skid_v};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a hold default first, so no path
    // through the case/if tree leaves it unassigned and no latch is inferred.
    main_v_n = main_v;
    main_p_n = main_p;
    main_c_n = main_c;
    skid_v_n = skid_v;
    skid_p_n = skid_p;
    skid_c_n = skid_c;

    if (flush) begin
      // Highest priority; no transfer can have happened this cycle.
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (SKID != 0) begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_v_n = 1'b1;
            main_p_n = in_payload;
            main_c_n = in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_p_n = in_payload;
            main_c_n = in_ctrl;
          end else if (in_fire) begin
            // Downstream stalled: park the new item behind the main entry.
            skid_v_n = 1'b1;
            skid_p_n = in_payload;
            skid_c_n = in_ctrl;
          end else if (out_fire) begin
            main_v_n = 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (out_fire) begin
            main_p_n = skid_p;
            main_c_n = skid_c;
            skid_v_n = 1'b0;
          end
        end
        default: begin
          main_v_n = 1'b0;
          skid_v_n = 1'b0;
        end
      endcase
    end else begin
      if (in_fire) begin
        main_v_n = 1'b1;
        main_p_n = in_payload;
        main_c_n = in_ctrl;
      end else if (out_fire) begin
        main_v_n = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_n = stall_cnt;
    if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt_n = stall_cnt + 16'd1;
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values of the others, independent of statement order.
    if (!sys_rst) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      // NOTE: the data entries are cleared too, so out_payload reads zero
      // after reset rather than whatever the flops powered up with.
      main_p    <= '0;
      main_c    <= '0;
      skid_p    <= '0;
      skid_c    <= '0;
      stall_cnt <= '0;
    end else begin
      main_v    <= main_v_n;
      main_p    <= main_p_n;
      main_c    <= main_c_n;
      skid_v    <= skid_v_n;
      skid_p    <= skid_p_n;
      skid_c    <= skid_c_n;
      stall_cnt <= stall_cnt_n;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Drives one SKID=1 and one SKID=0 instance from shared stimulus. Each
// instance is compared every cycle against a FIFO-level model (capacity 2 or
// 1, queue of items, stall counter); directed phases add literal expectations.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int PW = 100;
  localparam int CW = 16;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [CW-1:0] c;
  } item_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          in_valid;
  logic [PW-1:0] in_payload;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;
  logic          flush;

  logic          in_ready_a    [2];
  logic          out_valid_a   [2];
  logic [PW-1:0] out_payload_a [2];
  logic [CW-1:0] out_ctrl_a    [2];
  logic [1:0]    occ_a         [2];
  logic [15:0]   stall_cnt_a   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  id_ex_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .in_payload(in_payload), .in_ctrl(in_ctrl),
    .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .out_payload(out_payload_a[0]), .out_ctrl(out_ctrl_a[0]),
    .flush(flush), .occ(occ_a[0]), .stall_cnt(stall_cnt_a[0])
  );

  id_ex_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .in_payload(in_payload), .in_ctrl(in_ctrl),
    .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .out_payload(out_payload_a[1]), .out_ctrl(out_ctrl_a[1]),
    .flush(flush), .occ(occ_a[1]), .stall_cnt(stall_cnt_a[1])
  );

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per instance a FIFO of at most cap items, the payload of
  // the most recent head item (what the output shows while empty) and a
  // saturating stall counter. Index 0 = SKID=0 (cap 1), 1 = SKID=1 (cap 2).
  // ---------------------------------------------------------------------------
  item_t         mq     [2][2];
  int            mcnt   [2];
  logic [PW-1:0] mshown [2];
  logic [15:0]   mstall [2];
  bit            live = 1'b0;

  function automatic bit m_in_ready(int i);
    if (flush) return 1'b0;
    if (i == 1) return mcnt[i] < 2;
    return (mcnt[i] == 0) || out_ready;
  endfunction

  function automatic bit m_out_valid(int i);
    return (mcnt[i] > 0) && !flush;
  endfunction

  always @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst) begin
        mcnt[i]   = 0;
        mshown[i] = '0;
        mstall[i] = '0;
      end else begin
        bit ifire, ofire;
        ifire = in_valid && m_in_ready(i);
        ofire = m_out_valid(i) && out_ready;
        if (m_out_valid(i) && !out_ready && mstall[i] != 16'hFFFF)
          mstall[i] = mstall[i] + 16'd1;
        if (flush) begin
          mcnt[i] = 0;
        end else begin
          if (ofire) begin
            mq[i][0] = mq[i][1];
            mcnt[i]  = mcnt[i] - 1;
          end
          if (ifire) begin
            mq[i][mcnt[i]] = '{p: in_payload, c: in_ctrl};
            mcnt[i]        = mcnt[i] + 1;
          end
        end
        if (mcnt[i] > 0) mshown[i] = mq[i][0].p;
      end
    end
    if (!sys_rst) live = 1'b1;
  end

  // Compare every cycle on the falling edge, once the model has seen a reset.
  always @(negedge sys_clk) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        bit ov;
        ov = m_out_valid(i);
        check($sformatf("m%0d.in_ready", i),  in_ready_a[i],    m_in_ready(i));
        check($sformatf("m%0d.out_valid", i), out_valid_a[i],   ov);
        check($sformatf("m%0d.out_payload", i), out_payload_a[i],
              (mcnt[i] > 0) ? mq[i][0].p : mshown[i]);
        check($sformatf("m%0d.out_ctrl", i),  out_ctrl_a[i],
              ov ? mq[i][0].c : '0);
        check($sformatf("m%0d.occ", i),       occ_a[i],         mcnt[i]);
        check($sformatf("m%0d.stall_cnt", i), stall_cnt_a[i],   mstall[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [PW-1:0] p,
                       input logic [CW-1:0] c, input bit ordy, input bit fl);
    in_valid   = v;
    in_payload = p;
    in_ctrl    = c;
    out_ready  = ordy;
    flush      = fl;
  endtask

  initial begin
    logic [127:0] rnd;

    // Reset with in_valid high: the offered item is dropped.
    sys_rst = 1'b0;
    drive(1'b1, 'h3, 'h3, 1'b1, 1'b0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d.out_valid", i),   out_valid_a[i],   0);
      check($sformatf("rst%0d.out_ctrl", i),    out_ctrl_a[i],    0);
      check($sformatf("rst%0d.out_payload", i), out_payload_a[i], 0);
      check($sformatf("rst%0d.occ", i),         occ_a[i],         0);
      check($sformatf("rst%0d.stall_cnt", i),   stall_cnt_a[i],   0);
    end
    tick();
    sys_rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("rel.in_ready1", in_ready_a[1], 1);
    check("rel.in_ready0", in_ready_a[0], 1);

    // Streaming 1..8 with out_ready high.
    for (int k = 1; k <= 8; k++) begin
      tick();
      drive(1'b1, k, k, 1'b1, 1'b0);
      @(negedge sys_clk);
      if (k > 1) begin
        check($sformatf("stream.payload%0d", k - 1), out_payload_a[1], k - 1);
        check($sformatf("stream.occ%0d", k - 1), occ_a[1], 1);
      end
    end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("stream.payload8", out_payload_a[1], 8);
    tick();

    // Skid fill: A in main, stall, offer B then C.
    drive(1'b1, 'hA, 'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 'hB, 'h2, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("skid.b_ready", in_ready_a[1], 1);
    check("skid.head_a0", out_payload_a[1], 'hA);
    tick();
    drive(1'b1, 'hC, 'h3, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("skid.occ2", occ_a[1], 2);
    check("skid.c_held", in_ready_a[1], 0);
    check("skid.head_a1", out_payload_a[1], 'hA);
    tick();
    drive(1'b1, 'hC, 'h3, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("skid.out_a", out_payload_a[1], 'hA);
    tick();
    @(negedge sys_clk);
    check("skid.out_b", out_payload_a[1], 'hB);
    check("skid.c_ready", in_ready_a[1], 1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("skid.out_c", out_payload_a[1], 'hC);
    tick();

    // Flush with both entries full.
    drive(1'b1, 'hD, 'h4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 'hE, 'h5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 'hF, 'h6, 1'b1, 1'b1);
    @(negedge sys_clk);
    check("flush.out_valid", out_valid_a[1], 0);
    check("flush.in_ready", in_ready_a[1], 0);
    check("flush.out_ctrl", out_ctrl_a[1], 0);
    check("flush.occ_during", occ_a[1], 2);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("flush.occ_after", occ_a[1], 0);
    check("flush.valid_after", out_valid_a[1], 0);
    check("flush.ctrl_after", out_ctrl_a[1], 0);

    // Bubble: all-ones control drained with nothing behind it.
    tick();
    drive(1'b1, 'h55, 16'hFFFF, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("bubble.ctrl_live", out_ctrl_a[1], 16'hFFFF);
    tick();
    @(negedge sys_clk);
    check("bubble.valid", out_valid_a[1], 0);
    check("bubble.ctrl", out_ctrl_a[1], 0);
    check("bubble.stale_payload", out_payload_a[1], 'h55);

    // Randomised traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rnd = {$urandom, $urandom, $urandom, $urandom};
      sys_rst = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 1)), rnd[PW-1:0], 16'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    tick();
    sys_rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    tick();

    // Long stall: counter saturates and holds.
    drive(1'b1, 'h77, 'h9, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (70000) tick();
    @(negedge sys_clk);
    check("stall.sat1", stall_cnt_a[1], 16'hFFFF);
    check("stall.sat0", stall_cnt_a[0], 16'hFFFF);
    check("stall.valid1", out_valid_a[1], 1);

    // SKID=0: in_ready follows out_ready within the same cycle.
    tick();
    drive(1'b1, 'h5, 'h5, 1'b0, 1'b0);
    #1;
    check("s0.ready_low", in_ready_a[0], 0);
    out_ready = 1'b1;
    #1;
    check("s0.ready_high", in_ready_a[0], 1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) tick();
    @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Parametrised successor to the fixed-field ID/EX register. It carries an opaque payload bus and a control bus between any two adjacent pipeline stages using a valid/ready handshake. It adds stall back-pressure, an optional two-entry skid buffer, flush, bubble insertion and a stall-cycle counter. It sits between decode and execute in the five-stage pipeline and is reused at EX/MEM and MEM/WB.

## Interface
Parameters:
- PAYLOAD_W, default 100: width of the data payload (operands, store data).
- CTRL_W, default 16: width of the side-effecting control bits (dmem write enable, wb_select, write width, alu op, pc_sel, and so on).
- SKID, default 1: 1 selects a two-entry skid buffer with `in_ready` derived from registers plus `flush`; 0 selects a single register with a pass-through `in_ready`.

Ports:
- sys_clk, input, 1: single clock; all state updates on its rising edge.
- sys_rst, input, 1: synchronous, active-low reset.
- in_valid, input, 1: upstream stage presents an instruction.
- in_ready, output, 1: stage accepts this cycle.
- in_payload, input, PAYLOAD_W: upstream data.
- in_ctrl, input, CTRL_W: upstream control.
- out_valid, output, 1: downstream slot holds a live instruction.
- out_ready, input, 1: downstream accepts; low means stall.
- out_payload, output, PAYLOAD_W: main-entry data.
- out_ctrl, output, CTRL_W: main-entry control; all zero (bubble) whenever `out_valid` is 0.
- flush, input, 1: kill all contents (branch mispredict or trap).
- occ, output, 2: occupancy, 0 to 2.
- stall_cnt, output, 16: saturating count of stalled cycles.

## Operation
Definitions:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.

Storage:
- Main entry: main_v, main_p, main_c.
- Skid entry: skid_v, skid_p, skid_c. The skid entry exists only when SKID=1.

State is implied by {skid_v, main_v}:
- EMPTY (00)
- ONE (01)
- FULL (11)
- 10 is illegal and never reached.

SKID=1:
- in_ready = ~flush & ~skid_v.
- out_valid = main_v & ~flush.
- EMPTY: on in_fire, main <= in and go to ONE.
- ONE:
  - in_fire & out_fire: main <= in; stay in ONE.
  - in_fire & ~out_fire: skid <= in; go to FULL.
  - ~in_fire & out_fire: go to EMPTY.
  - Neither: hold.
- FULL:
  - out_fire: main <= skid, skid_v <= 0; go to ONE.
  - Otherwise hold. No input is accepted in FULL.

SKID=0:
- in_ready = ~flush & (~main_v | out_ready).
- Only EMPTY and ONE exist.
- in_fire loads main.
- out_fire without in_fire clears main_v.

Flush:
- Highest priority.
- During the flush cycle both in_ready and out_valid are 0, so no transfer occurs in either direction.
- At the next edge main_v <= 0 and skid_v <= 0.

Bubble:
- out_ctrl = main_v & ~flush ? main_c : 0.
- A bubble therefore never triggers a dmem write, register writeback or pc redirect.
- out_payload always shows main_p, including the stale value while invalid.

Occupancy:
- occ = main_v + skid_v. This is the registered value and is not gated by flush.

stall_cnt:
- Increments by 1 on every cycle with out_valid & ~out_ready.
- Saturates at 0xFFFF.
- Cleared only by reset.

Reset, while sys_rst is low at an edge:
- main_v = 0, skid_v = 0.
- main_p, main_c, skid_p and skid_c are cleared to 0.
- stall_cnt = 0.

Resulting output values after reset:
- out_valid = 0, out_payload = 0, out_ctrl = 0, occ = 0, stall_cnt = 0.
- in_ready = 1 when flush = 0.
- Reset mid-transfer discards both entries. An in_fire during the reset cycle is dropped.

## Timing
- Latency: an item accepted at edge t appears on out_* in the cycle after t.
- Throughput: one item per cycle while out_ready stays high, in both SKID modes.
- SKID=1:
  - in_ready depends only on skid_v and flush. There is no combinational path from out_ready to in_ready.
  - A single stall cycle costs no upstream bubble, because the skid absorbs one item.
- SKID=0: in_ready depends combinationally on out_ready.
- Simultaneous in_fire and out_fire in ONE keeps the occupancy unchanged.
- Simultaneous flush and in_valid: the input is not accepted, because in_ready is 0. Upstream must hold or drop it per its own flush.
- Order is strictly FIFO. The skid item is never overtaken.

## Test plan
- Reset: hold sys_rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occ=0, stall_cnt=0. After release, in_ready=1.
- Streaming: SKID=1, out_ready=1, send payloads 1..8 on consecutive cycles -> out_payload 1..8 on consecutive cycles, each one cycle later, occ stays 1.
- Skid fill: drop out_ready after item A is in main and send B, C -> B is accepted, occ=2, in_ready=0, C is held. Raise out_ready -> A, B, C emerge in order.
- Flush: occ=2 and flush=1 for one cycle -> out_valid=0 and in_ready=0 during the flush cycle, occ=0 at the next edge, out_ctrl=0.
- Bubble: in_ctrl=16'hFFFF accepted then drained with no new input -> out_ctrl=0 once out_valid falls.
- Stall counter: hold out_ready=0 with main valid for 70000 cycles -> stall_cnt=16'hFFFF and holds. SKID=0 repeat: in_ready follows out_ready in the same cycle.
